// File: rtl/fp_force_accum.sv
// fp_force_accum: per-entry FP force accumulator driving an external pipelined FP adder, with clear and dump readout.
// Optional macro FP_FORCE_ACCUM_STALL_CNT_EN adds a saturating input-stall counter output.
module fp_force_accum #(
    parameter int DEPTH       = 16,
    parameter int ID_W        = 4,
    parameter int ADD_LATENCY = 2
) (
    input  logic            clk,
    input  logic            aclr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_id,
    input  logic [31:0]     in_force,
    output logic            add_ena,
    output logic [31:0]     add_ax,
    output logic [31:0]     add_ay,
    input  logic [31:0]     add_result,
    input  logic            dump_start,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic [31:0]     out_force,
    output logic            out_last
`ifdef FP_FORCE_ACCUM_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);
    typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, DUMP} state_t;
    localparam logic [ID_W:0] LAST = (ID_W + 1)'(DEPTH - 1);
    localparam logic [ID_W:0] FULL = (ID_W + 1)'(DEPTH);
    state_t state, state_n;
    logic [ID_W:0] idx, idx_n;
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data, force_q, wr_data;
    logic [ID_W-1:0] rd_addr, wr_addr;
    logic wr_en, hazard, accept, busy;
    logic [ADD_LATENCY:0] pipe_v;
    logic [ID_W-1:0] pipe_id [ADD_LATENCY+1];
    // Every pipe stage is an accepted op whose sum is not yet back in memory.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i <= ADD_LATENCY; i++) hazard = hazard | (pipe_v[i] && pipe_id[i] == in_id);
    end
    assign busy      = |pipe_v;
    assign in_ready  = state == ACCUM && !hazard;
    assign accept    = in_valid && in_ready;
    assign add_ena   = busy;
    assign add_ax    = pipe_v[0] ? rd_data : 32'd0;
    assign add_ay    = pipe_v[0] ? force_q : 32'd0;
    assign out_force = out_valid ? rd_data : 32'd0;
    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            CLEAR: begin
                state_n = idx == LAST ? ACCUM : CLEAR;
                idx_n   = idx == LAST ? '0 : idx + 1'b1;
            end
            ACCUM: state_n = dump_start ? DRAIN : ACCUM;
            DRAIN: begin
                state_n = busy ? DRAIN : DUMP;
                idx_n   = '0;
            end
            default: begin
                state_n = idx == FULL ? ACCUM : DUMP;
                idx_n   = idx == FULL ? '0 : idx + 1'b1;
            end
        endcase
    end
    // One write port shared by clear, dump-clear and adder writeback; they never coincide.
    always_comb begin
        rd_addr = state == DUMP ? idx[ID_W-1:0] : in_id;
        wr_en   = state == CLEAR || (state == DUMP && !idx[ID_W]) || pipe_v[ADD_LATENCY];
        wr_addr = pipe_v[ADD_LATENCY] ? pipe_id[ADD_LATENCY] : idx[ID_W-1:0];
        wr_data = pipe_v[ADD_LATENCY] ? add_result : 32'd0;
    end
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= CLEAR;
            idx       <= '0;
            pipe_v    <= '0;
            force_q   <= 32'd0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_last  <= 1'b0;
            for (int i = 0; i <= ADD_LATENCY; i++) pipe_id[i] <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            pipe_v    <= {pipe_v[ADD_LATENCY-1:0], accept};
            pipe_id[0] <= in_id;
            for (int i = 1; i <= ADD_LATENCY; i++) pipe_id[i] <= pipe_id[i-1];
            if (accept) force_q <= in_force;
            out_valid <= state == DUMP && !idx[ID_W];
            out_id    <= idx[ID_W-1:0];
            out_last  <= state == DUMP && idx == LAST;
        end
    end
`ifdef FP_FORCE_ACCUM_STALL_CNT_EN
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) stall_cnt <= 16'd0;
        else if (state_n == DUMP && state != DUMP) stall_cnt <= 16'd0;
        else if (state == ACCUM && in_valid && !in_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fp_force_accum.sv
// tb_fp_force_accum: scoreboard bench for fp_force_accum with a 2-stage integer-valued FP adder model.
module tb_fp_force_accum;
    logic clk = 1'b0, aclr, in_valid, in_ready, add_ena, dump_start, out_valid, out_last;
    logic [3:0] in_id, out_id;
    logic [31:0] in_force, add_ax, add_ay, add_result, out_force, s1, s2;
`ifdef FP_FORCE_ACCUM_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    typedef struct {logic [3:0] id; logic [31:0] f; logic last;} exp_t;
    exp_t q[$];
    int model [16];
    int total = 0, fails = 0;

    fp_force_accum dut (
        .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_force(in_force), .add_ena(add_ena), .add_ax(add_ax), .add_ay(add_ay),
        .add_result(add_result), .dump_start(dump_start), .out_valid(out_valid),
        .out_id(out_id), .out_force(out_force), .out_last(out_last)
`ifdef FP_FORCE_ACCUM_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int f2i(input logic [31:0] b);
        int e, m;
        if (b[30:0] == 31'd0) return 0;
        e = int'(b[30:23]) - 127;
        m = int'({1'b1, b[22:0]});
        return m >>> (23 - e);
    endfunction

    function automatic logic [31:0] i2f(input int v);
        int p;
        logic [31:0] m;
        if (v == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 31; i++) if (v[i]) p = i;
        m = 32'(v) << (23 - p);
        return {1'b0, 8'(p + 127), m[22:0]};
    endfunction

    always @(posedge clk) if (add_ena) begin
        s1 <= i2f(f2i(add_ax) + f2i(add_ay));
        s2 <= s1;
    end
    assign add_result = s2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clear();
        int low = 0;
        logic ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else low++;
        end
        chk("clear_cycles", 32'(low), 32'd16);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [3:0] id, input logic [31:0] f, output int stalls);
        logic ok = 1'b0;
        in_valid = 1'b1; in_id = id; in_force = f; stalls = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) stalls++;
            @(posedge clk); #1;
        end
        chk("send_accepted", 32'(ok), 32'd1);
        model[id] += f2i(f);
    endtask

    task automatic push_dump();
        for (int i = 0; i < 16; i++) begin
            q.push_back('{4'(i), i2f(model[i]), i == 15});
            model[i] = 0;
        end
    endtask

    task automatic collect();
        exp_t e;
        for (int k = 0; k < 200 && q.size() > 0; k++) begin
            @(negedge clk);
            if (out_valid) begin
                e = q.pop_front();
                total++;
                if (out_id !== e.id || out_force !== e.f || out_last !== e.last) begin
                    fails++;
                    $display("FAIL dump_word: got id %0d force %h last %b expected id %0d force %h last %b",
                             out_id, out_force, out_last, e.id, e.f, e.last);
                end
            end
        end
        chk("dump_complete_left", 32'(q.size()), 32'd0);
        q.delete();
        @(negedge clk);
        chk("dump_no_extra", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_dump();
        push_dump();
        dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        collect();
    endtask

    task automatic test_reset();
        aclr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_add_ena", 32'(add_ena), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_add_ax", add_ax, 32'd0);
        chk("rst_add_ay", add_ay, 32'd0);
        chk("rst_out_force", out_force, 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        @(posedge clk); #1;
        aclr = 1'b0;
        wait_clear();
    endtask

    task automatic test_zero_dump();
        do_dump();
    endtask

    task automatic test_two_ids();
        int s;
        send(4'd3, 32'h3F800000, s);
        chk("two_ids_stall_a", 32'(s), 32'd0);
        send(4'd5, 32'h40000000, s);
        chk("two_ids_stall_b", 32'(s), 32'd0);
        in_valid = 1'b0;
        do_dump();
    endtask

    task automatic test_same_id();
        int s;
        send(4'd7, 32'h3F800000, s);
        chk("same_id_stall_1", 32'(s), 32'd0);
        send(4'd7, 32'h3F800000, s);
        chk("same_id_stall_2", 32'(s), 32'd3);
        send(4'd7, 32'h3F800000, s);
        chk("same_id_stall_3", 32'(s), 32'd3);
        in_valid = 1'b0;
`ifdef FP_FORCE_ACCUM_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd6);
`endif
        chk("same_id_model", i2f(model[7]), 32'h40400000);
        do_dump();
    endtask

    task automatic test_dump_twice();
        int s;
        send(4'd1, 32'h40000000, s);
        in_valid = 1'b0;
        do_dump();
        do_dump();
    endtask

    task automatic test_dump_with_sample();
        in_valid = 1'b1; in_id = 4'd9; in_force = 32'h3F800000; dump_start = 1'b1;
        @(negedge clk);
        chk("dump_sample_ready", 32'(in_ready), 32'd1);
        model[9] += 1;
        @(posedge clk); #1;
        in_valid = 1'b0; dump_start = 1'b0;
        @(negedge clk);
        chk("dump_pending_ready", 32'(in_ready), 32'd0);
        push_dump();
        collect();
    endtask

    task automatic test_reset_mid_dump();
        int s;
        logic hit = 1'b0;
        send(4'd8, 32'h40000000, s);
        in_valid = 1'b0;
        dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            hit = out_valid && out_id == 4'd8;
        end
        chk("mid_dump_reached_8", 32'(hit), 32'd1);
        chk("mid_dump_force_8", out_force, 32'h40000000);
        aclr = 1'b1;
        #1;
        chk("mid_dump_valid_drop", 32'(out_valid), 32'd0);
        chk("mid_dump_last_drop", 32'(out_last), 32'd0);
        @(posedge clk); #1;
        aclr = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 0;
        wait_clear();
        do_dump();
    endtask

    initial begin
        aclr = 1'b1; in_valid = 1'b0; dump_start = 1'b0; in_id = 4'd0; in_force = 32'd0;
        for (int i = 0; i < 16; i++) model[i] = 0;
        test_reset();
        test_zero_dump();
        test_two_ids();
        test_same_id();
        test_dump_twice();
        test_dump_with_sample();
        test_reset_mid_dump();
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
